// File: rtl/mult_cpa_pipe.sv
// mult_cpa_pipe: two-stage carry-propagate adder for the carry-save vectors of the 16x16 multiplier
module mult_cpa_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             cout
);
    localparam int HI = WIDTH - SPLIT;
    logic             s1_valid, s1_c, s2_valid, s2_adv;
    logic [SPLIT-1:0] s1_lo;
    logic [HI-1:0]    s1_ahi, s1_bhi;
    logic [SPLIT:0]   sum_lo;
    logic [HI:0]      sum_hi;
    // handshake advance terms and the two slice adders
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
        sum_lo   = {1'b0, in_a[SPLIT-1:0]} + {1'b0, in_b[SPLIT-1:0]};
        sum_hi   = {1'b0, s1_ahi} + {1'b0, s1_bhi} + {{HI{1'b0}}, s1_c};
    end
    // valid bits and the result registers; an idle input slot empties stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            product  <= '0;
            cout     <= 1'b0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    {cout, product} <= {sum_hi, s1_lo};
            end
        end
    end
    // stage-1 data is qualified by s1_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            {s1_c, s1_lo} <= sum_lo;
            s1_ahi        <= in_a[WIDTH-1:SPLIT];
            s1_bhi        <= in_b[WIDTH-1:SPLIT];
        end
    end
    assign out_valid = s2_valid;
endmodule
